branch_bht: RTL and testbench
=============================

# branch_bht

Parametrised branch resolution and direction-prediction unit for the pipelined RISC-V core, succeeding the single-cycle jump decoder. Fetch stage: predicts taken/not-taken for the current PC from a table of 2-bit saturating counters. Execute stage: resolves the actual branch outcome from ALU flags, flags mispredictions for pipeline redirect, and trains the table. Also keeps branch and misprediction performance counters.

## Interface

- XLEN, 32: PC width.
- BHT_ENTRIES, 64: counter table depth; power of two, ≥ 2. IDX_W = log2(BHT_ENTRIES).
- CNT_INIT, 2'b01: reset value of every table counter (weakly not-taken).
- PERF_W, 32: width of performance counters.

Ports:

- clk, input, 1: clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- PCF, input, XLEN: fetch-stage PC.
- PredTakenF, output, 1: prediction for PCF.
- ValidE, input, 1: execute-stage instruction valid (not bubble/flushed).
- opE, input, 7: execute-stage opcode.
- funct3E, input, 3: execute-stage funct3.
- PCE, input, XLEN: execute-stage PC, used for the table index.
- PredTakenE, input, 1: PredTakenF value carried down the pipeline with the instruction.
- Zero, Overflow, Carry, Negative, input, 1 each: ALU flags of rs1 − rs2. Carry = 1 means no borrow.
- TakenE, output, 1: resolved control-transfer decision.
- RedirectE, output, 1: fetch must be redirected and younger instructions flushed.
- BranchCnt, output, PERF_W: conditional branches resolved.
- MissCnt, output, PERF_W: conditional branches mispredicted.

## Operation

Index:

- idx(pc) = pc[IDX_W+1:2].
- PredTakenF = bht[idx(PCF)][1].
- The prediction is produced for every PC. Fetch only uses it when predecode identifies a branch.

Resolution (combinational, execute stage). Conditional branches have opE = 1100011:

- funct3 000 beq: Zero.
- funct3 001 bne: ~Zero.
- funct3 100 blt: Negative ^ Overflow.
- funct3 101 bge: ~(Negative ^ Overflow).
- funct3 110 bltu: ~Carry.
- funct3 111 bgeu: Carry.
- funct3 010/011: invalid. Not taken, no training, not counted.

Other opcodes:

- jal (1101111) and jalr (1100111): TakenE = 1.
- Any other opcode: TakenE = 0.
- ValidE = 0 forces TakenE = 0 and RedirectE = 0.

Redirect:

- Signals: brv = ValidE & valid conditional branch; jmp = ValidE & (jal | jalr).
- RedirectE = jmp | (brv & (TakenE != PredTakenE)).
- If a branch is mispredicted taken but actually not taken, the redirect target is PCE+4. The target mux is outside this block.

Training, on the clock edge when brv = 1, at bht[idx(PCE)]:

- Taken: counter increments, saturating at 3.
- Not taken: counter decrements, saturating at 0.
- jal/jalr do not train.

Performance counters:

- BranchCnt += 1 when brv = 1.
- MissCnt += 1 when brv = 1 and TakenE != PredTakenE.
- Both wrap modulo 2^PERF_W.

## Timing

- Reset: every bht entry = CNT_INIT; BranchCnt = MissCnt = 0. Outputs after reset: PredTakenF = CNT_INIT[1] (0 by default); TakenE and RedirectE follow their inputs combinationally.
- Reset asserted mid-update: the update is discarded and the table goes to CNT_INIT.
- PredTakenF, TakenE and RedirectE are combinational, with zero-cycle latency.
- Table update is visible on PredTakenF one cycle after the training edge.
- Same-cycle read/write to one index: PredTakenF returns the pre-update value (no bypass).
- Aliasing: PCs equal modulo BHT_ENTRIES·4 share an entry. This is intended.
- Performance counters update on the same edge as training.

## Test plan

- Reset with BHT_ENTRIES=64. Sweep PCF over 0x0..0xFC → PredTakenF = 0 everywhere; BranchCnt = MissCnt = 0.
- Saturation: beq with Zero=1 at PCE=0x40 for 4 consecutive cycles. The counter goes 01→10→11→11. PredTakenF at PCF=0x40 rises one cycle after the first edge. Then 4 not-taken → 11→10→01→00→00.
- Flag decode: rs1=−1, rs2=1. blt → taken (N^V=1); bltu → not taken (Carry=1); bge/bgeu → complements. With PredTakenE=0, RedirectE matches TakenE. BranchCnt = 4, MissCnt = 2.
- Jumps and bubbles: jal and jalr with ValidE=1 → TakenE=1, RedirectE=1, table and counters unchanged. Any branch with ValidE=0 → no redirect, no training. funct3=010 → not taken, not counted.
- Aliasing and same-cycle hazard: train PCE=0x100 taken while PCF=0x000. PredTakenF shows the old value that cycle and the new value on the next cycle.
- Async reset mid-stream: assert reset between edges after training → PredTakenF drops to 0 immediately. Counters read 0 before the next clk edge.

Source files
------------

// File: rtl/branch_bht.sv
// Branch direction predictor (2-bit saturating counter table) with execute-stage
// branch resolution, redirect generation, table training and perf counters.
module branch_bht #(
  parameter int          XLEN        = 32,
  parameter int          BHT_ENTRIES = 64,
  parameter logic [1:0]  CNT_INIT    = 2'b01,
  parameter int          PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   PCF,
  output logic              PredTakenF,
  input  logic              ValidE,
  input  logic [6:0]        opE,
  input  logic [2:0]        funct3E,
  input  logic [XLEN-1:0]   PCE,
  input  logic              PredTakenE,
  input  logic              Zero,
  input  logic              Overflow,
  input  logic              Carry,
  input  logic              Negative,
  output logic              TakenE,
  output logic              RedirectE,
  output logic [PERF_W-1:0] BranchCnt,
  output logic [PERF_W-1:0] MissCnt
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;
  logic [PERF_W-1:0]           branch_cnt_q, branch_cnt_d;
  logic [PERF_W-1:0]           miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic             cond, f3_ok, brv, jmp, miss;
  logic [1:0]       cnt_e;

  assign idx_f = PCF[IDX_W+1:2];
  assign idx_e = PCE[IDX_W+1:2];

  // Read is straight from the flops, so a same-cycle write is not bypassed.
  assign PredTakenF = bht_q[idx_f][1];

  always_comb begin
    cond  = 1'b0;
    f3_ok = 1'b1;
    case (funct3E)
      3'b000:  cond = Zero;
      3'b001:  cond = ~Zero;
      3'b100:  cond = Negative ^ Overflow;
      3'b101:  cond = ~(Negative ^ Overflow);
      3'b110:  cond = ~Carry;
      3'b111:  cond = Carry;
      default: f3_ok = 1'b0;
    endcase

    brv       = ValidE & (opE == OP_BRANCH) & f3_ok;
    jmp       = ValidE & ((opE == OP_JAL) | (opE == OP_JALR));
    TakenE    = jmp | (brv & cond);
    miss      = brv & (TakenE != PredTakenE);
    RedirectE = jmp | miss;

    bht_d        = bht_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    cnt_e        = bht_q[idx_e];
    if (brv) begin
      if (cond && cnt_e != 2'b11)       cnt_e = cnt_e + 2'b01;
      else if (!cond && cnt_e != 2'b00) cnt_e = cnt_e - 2'b01;
      bht_d[idx_e] = cnt_e;
      branch_cnt_d = branch_cnt_q + 1'b1;
      if (miss) miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bht_q        <= {BHT_ENTRIES{CNT_INIT}};
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      bht_q        <= bht_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign BranchCnt = branch_cnt_q;
  assign MissCnt   = miss_cnt_q;
endmodule

// File: tb/tb_branch_bht.sv
// Scoreboard bench for branch_bht: stimulus pushes expected values, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_branch_bht;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PCF = '0, PCE = '0;
  logic        PredTakenF, ValidE = 1'b0, PredTakenE = 1'b0;
  logic [6:0]  opE = '0;
  logic [2:0]  funct3E = '0;
  logic        Zero = 1'b0, Overflow = 1'b0, Carry = 1'b0, Negative = 1'b0;
  logic        TakenE, RedirectE;
  logic [31:0] BranchCnt, MissCnt;

  branch_bht dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF),
    .ValidE(ValidE), .opE(opE), .funct3E(funct3E), .PCE(PCE),
    .PredTakenE(PredTakenE), .Zero(Zero), .Overflow(Overflow),
    .Carry(Carry), .Negative(Negative), .TakenE(TakenE),
    .RedirectE(RedirectE), .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pred;
    logic        taken;
    logic        redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    n_cmp = 0, n_err = 0;

  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] ALU = 7'b0110011;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s.%s: got %0h want %0h", nm, fld, got, want);
    end
  endtask

  // Monitor: each cycle with a pending expectation, compare the live outputs.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        chk(nm, "PredTakenF", {31'b0, PredTakenF}, {31'b0, e.pred});
        chk(nm, "TakenE",     {31'b0, TakenE},     {31'b0, e.taken});
        chk(nm, "RedirectE",  {31'b0, RedirectE},  {31'b0, e.redir});
        chk(nm, "BranchCnt",  BranchCnt,           e.bc);
        chk(nm, "MissCnt",    MissCnt,             e.mc);
      end
    end
  end

  // zvcn = {Zero, Overflow, Carry, Negative}
  task automatic drv(input string nm, input logic [31:0] pcf, input logic v,
                     input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pce,
                     input logic pe, input logic [3:0] zvcn,
                     input logic ep, input logic et, input logic er,
                     input int bc, input int mc);
    exp_t e;
    @(posedge clk); #1;
    PCF = pcf; ValidE = v; opE = op; funct3E = f3; PCE = pce; PredTakenE = pe;
    {Zero, Overflow, Carry, Negative} = zvcn;
    e.pred = ep; e.taken = et; e.redir = er; e.bc = bc; e.mc = mc;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic [31:0] pcf, input logic ep,
                      input int bc, input int mc);
    drv(nm, pcf, 1'b0, 7'h00, 3'b000, 32'h0, 1'b0, 4'b0000, ep, 1'b0, 1'b0, bc, mc);
  endtask

  initial begin
    exp_t e;
    int   wait_cyc;
    #12 reset = 1'b0;

    for (int pc = 0; pc <= 'hFC; pc += 4) idle("sweep", pc, 1'b0, 0, 0);

    // Saturate up at idx 0x10, then down; PredTakenE=0 then 1 so every one misses.
    drv("sat_up1", 32'h40, 1, BR, 3'b000, 32'h40, 0, 4'b1000, 0, 1, 1, 0, 0);
    drv("sat_up2", 32'h40, 1, BR, 3'b000, 32'h40, 0, 4'b1000, 1, 1, 1, 1, 1);
    drv("sat_up3", 32'h40, 1, BR, 3'b000, 32'h40, 0, 4'b1000, 1, 1, 1, 2, 2);
    drv("sat_up4", 32'h40, 1, BR, 3'b000, 32'h40, 0, 4'b1000, 1, 1, 1, 3, 3);
    drv("sat_dn1", 32'h40, 1, BR, 3'b000, 32'h40, 1, 4'b0000, 1, 0, 1, 4, 4);
    drv("sat_dn2", 32'h40, 1, BR, 3'b000, 32'h40, 1, 4'b0000, 1, 0, 1, 5, 5);
    drv("sat_dn3", 32'h40, 1, BR, 3'b000, 32'h40, 1, 4'b0000, 0, 0, 1, 6, 6);
    drv("sat_dn4", 32'h40, 1, BR, 3'b000, 32'h40, 1, 4'b0000, 0, 0, 1, 7, 7);
    idle("sat_end", 32'h40, 0, 8, 8);

    // rs1=-1, rs2=1: Z=0 V=0 C=1 N=1
    drv("blt",  32'h80, 1, BR, 3'b100, 32'h80, 0, 4'b0011, 0, 1, 1, 8, 8);
    drv("bltu", 32'h80, 1, BR, 3'b110, 32'h80, 0, 4'b0011, 1, 0, 0, 9, 9);
    drv("bge",  32'h80, 1, BR, 3'b101, 32'h80, 0, 4'b0011, 0, 0, 0, 10, 9);
    drv("bgeu", 32'h80, 1, BR, 3'b111, 32'h80, 0, 4'b0011, 0, 1, 1, 11, 9);
    idle("flags_end", 32'h80, 0, 12, 10);

    drv("jal",     32'h80, 1, JAL,  3'b000, 32'h80, 0, 4'b0000, 0, 1, 1, 12, 10);
    drv("jalr",    32'h80, 1, JALR, 3'b000, 32'h80, 0, 4'b0000, 0, 1, 1, 12, 10);
    drv("jal_pe1", 32'h80, 1, JAL,  3'b000, 32'h80, 1, 4'b0000, 0, 1, 1, 12, 10);
    drv("bubble1", 32'h80, 0, BR,   3'b000, 32'h80, 0, 4'b1000, 0, 0, 0, 12, 10);
    drv("bubble2", 32'h80, 0, BR,   3'b000, 32'h80, 0, 4'b1000, 0, 0, 0, 12, 10);
    drv("f3_010",  32'h80, 1, BR,   3'b010, 32'h80, 1, 4'b1011, 0, 0, 0, 12, 10);
    drv("f3_011",  32'h80, 1, BR,   3'b011, 32'h80, 1, 4'b1011, 0, 0, 0, 12, 10);
    drv("alu_op",  32'h80, 1, ALU,  3'b000, 32'h80, 1, 4'b1000, 0, 0, 0, 12, 10);
    idle("jmp_end", 32'h80, 0, 12, 10);

    // 0x100 aliases idx 0; fetch of 0x000 sees the old counter during the write.
    drv("alias_wr", 32'h000, 1, BR, 3'b000, 32'h100, 0, 4'b1000, 0, 1, 1, 12, 10);
    idle("alias_rd0",   32'h000, 1, 13, 11);
    idle("alias_rd100", 32'h100, 1, 13, 11);

    // Async reset between edges.
    @(posedge clk); #1;
    PCF = 32'h0; ValidE = 1'b0;
    #1 reset = 1'b1;
    e.pred = 0; e.taken = 0; e.redir = 0; e.bc = 0; e.mc = 0;
    sb_q.push_back(e); nm_q.push_back("async_rst");
    @(negedge clk); #1 reset = 1'b0;
    idle("post_rst0",  32'h00, 0, 0, 0);
    idle("post_rst40", 32'h40, 0, 0, 0);

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_cmp++;
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
